// File: rtl/square_pkg.sv
// Shared fixed-point definitions for the square and square-root units:
// default Q-format split and the 2-bit FSM state encoding both units expose.
`timescale 1ns/1ps
package square_pkg;

  localparam int FXP_IL = 4;
  localparam int FXP_FL = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_BUSY    = 2'b01,
    ST_DONE    = 2'b10,
    ST_ILLEGAL = 2'b11
  } fxp_state_e;

endpackage

// File: rtl/square.sv
// Unsigned fixed-point squarer: x*x by sequential shift-add (one multiplier bit
// per cycle), then round-half-up to QIL.FL with saturation.
`timescale 1ns/1ps
module square
  import square_pkg::*;
#(
  parameter int IL = FXP_IL,
  parameter int FL = FXP_FL
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IL+FL-1:0]  in,
  input  logic              input_ready,
  input  logic              output_taken,
  output logic [IL+FL-1:0]  out,
  output logic [1:0]        state,
  output logic              done,
  output logic              overflow
);

  localparam int W  = IL + FL;
  localparam int PW = 2 * W;
  localparam int CW = $clog2(W + 1);
  localparam int RW = PW - FL + 1;

  // Handshake: input_ready is an operand-valid strobe honoured only in IDLE
  // (the operand is latched on that edge); output_taken acknowledges the
  // result and is honoured only in DONE. Neither is queued in other states.

  fxp_state_e     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]  mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [PW-1:0]  acc_q, acc_d;
  logic [W-1:0]   out_q, out_d;
  logic           ovf_q, ovf_d;

  logic [PW-1:0]  acc_sum;
  logic [PW:0]    biased;
  logic [RW-1:0]  rnd;
  logic           sat;

  // Adding half an LSB before truncation gives P>>FL plus P[FL-1].
  always_comb begin
    acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
    biased  = {1'b0, acc_sum} + ((PW+1)'(1) << (FL - 1));
    rnd     = RW'(biased >> FL);
    sat     = |rnd[RW-1:W];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    out_d    = out_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (input_ready) begin
          state_d  = ST_BUSY;
          mcand_d  = PW'(in);
          mplier_d = in;
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      ST_BUSY: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          state_d = ST_DONE;
          out_d   = sat ? '1 : rnd[W-1:0];
          ovf_d   = sat;
        end
      end
      ST_DONE: begin
        if (output_taken) begin
          state_d  = ST_IDLE;
          cnt_d    = '0;
          mcand_d  = '0;
          mplier_d = '0;
          acc_d    = '0;
          out_d    = '0;
          ovf_d    = 1'b0;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        cnt_d    = '0;
        mcand_d  = '0;
        mplier_d = '0;
        acc_d    = '0;
        out_d    = '0;
        ovf_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      out_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      out_q    <= out_d;
      ovf_q    <= ovf_d;
    end
  end

  // Result is gated by state so no partial value can ever leak onto out.
  assign state    = state_q;
  assign done     = (state_q == ST_DONE);
  assign out      = done ? out_q : '0;
  assign overflow = done & ovf_q;

endmodule

// File: tb/tb_square.sv
// Self-checking bench for square: directed corner operands, randomized operands
// against an arithmetic reference, handshake corner cases and async reset.
`timescale 1ns/1ps
module tb_square;
  import square_pkg::*;

  localparam int IL = FXP_IL;
  localparam int FL = FXP_FL;
  localparam int W  = IL + FL;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         input_ready = 1'b0;
  logic         output_taken = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] out;
  logic [1:0]   state;
  logic         done;
  logic         overflow;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  square #(.IL(IL), .FL(FL)) dut (
    .clk          (clk),
    .reset        (reset),
    .in           (din),
    .input_ready  (input_ready),
    .output_taken (output_taken),
    .out          (out),
    .state        (state),
    .done         (done),
    .overflow     (overflow)
  );

  // Reference: round(x*x / 2^FL) half up, saturate to W bits. Returns {ovf, out}.
  function automatic logic [W:0] model(input logic [W-1:0] x);
    longint unsigned p, r, maxv;
    p    = longint'(x) * longint'(x);
    r    = (p + (64'd1 << (FL - 1))) >> FL;
    maxv = (64'd1 << W) - 1;
    if (r > maxv) return {1'b1, {W{1'b1}}};
    return {1'b0, r[W-1:0]};
  endfunction

  // Accept x, then wait (bounded) for done; edges counts the accept edge as 1.
  task automatic run_op(input logic [W-1:0] x, input bit noise,
                        output int edges, output bit leak);
    @(negedge clk);
    din = x;
    input_ready = 1'b1;
    @(posedge clk);
    edges = 1;
    leak = 1'b0;
    @(negedge clk);
    input_ready = 1'b0;
    while (!done && edges < 4 * W) begin
      if (out !== '0 || overflow !== 1'b0 || state !== 2'b01) leak = 1'b1;
      if (noise) begin
        input_ready = 1'($urandom_range(0, 1));
        din = W'($urandom);
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    input_ready = 1'b0;
  endtask

  task automatic take_result(input string name);
    @(negedge clk);
    output_taken = 1'b1;
    @(posedge clk);
    @(negedge clk);
    output_taken = 1'b0;
    checks++;
    if (state !== 2'b00 || out !== '0 || overflow !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL %s_take: state=%b out=%h ovf=%b done=%b expected state=00 out=0 ovf=0 done=0",
               name, state, out, overflow, done);
    end
  endtask

  task automatic check_op(input string name, input logic [W-1:0] x, input bit noise,
                          output logic [W:0] got);
    int edges;
    bit leak;
    logic [W:0] exp;
    run_op(x, noise, edges, leak);
    exp = model(x);
    got = {overflow, out};
    checks++;
    if (edges != W + 1) begin
      failures++;
      $display("FAIL %s_latency: in=%h edges=%0d expected %0d", name, x, edges, W + 1);
    end
    checks++;
    if (leak) begin
      failures++;
      $display("FAIL %s_busy_out: in=%h out/overflow nonzero or state not BUSY before done", name, x);
    end
    checks++;
    if (done !== 1'b1 || state !== 2'b10) begin
      failures++;
      $display("FAIL %s_done: done=%b state=%b expected done=1 state=10", name, done, state);
    end
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s_result: in=%h out=%h ovf=%b expected out=%h ovf=%b",
               name, x, got[W-1:0], got[W], exp[W-1:0], exp[W]);
    end
    take_result(name);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    checks++;
    if (state !== 2'b00 || out !== '0 || done !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: state=%b out=%h done=%b ovf=%b expected all zero",
               state, out, done, overflow);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (state !== 2'b00) begin
      failures++;
      $display("FAIL reset_idle_hold: state=%b expected 00", state);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] xs [6];
    logic [W:0]   lit [6];
    logic [W:0]   got;
    xs[0] = 20'h20000; lit[0] = {1'b0, 20'h40000};
    xs[1] = 20'h18000; lit[1] = {1'b0, 20'h24000};
    xs[2] = 20'h000B5; lit[2] = {1'b0, 20'h00000};
    xs[3] = 20'h000B6; lit[3] = {1'b0, 20'h00001};
    xs[4] = 20'h40000; lit[4] = {1'b1, 20'hFFFFF};
    xs[5] = 20'hFFFFF; lit[5] = {1'b1, 20'hFFFFF};
    for (int i = 0; i < 6; i++) begin
      check_op($sformatf("directed%0d", i), xs[i], 1'b0, got);
      checks++;
      if (got !== lit[i]) begin
        failures++;
        $display("FAIL directed%0d_const: in=%h out=%h ovf=%b expected out=%h ovf=%b",
                 i, xs[i], got[W-1:0], got[W], lit[i][W-1:0], lit[i][W]);
      end
    end
  endtask

  task automatic test_random();
    logic [W:0]   got;
    logic [W-1:0] x;
    for (int i = 0; i < 24; i++) begin
      case (i % 3)
        0: x = W'($urandom_range(0, (1 << W) - 1));
        1: x = W'($urandom_range(0, 1 << (FL / 2 + 1)));
        default: x = W'($urandom_range((1 << (W - IL / 2)) - 64, (1 << (W - IL / 2)) + 64));
      endcase
      check_op($sformatf("random%0d", i), x, 1'($urandom_range(0, 1)), got);
    end
  endtask

  task automatic test_hold_and_ignore();
    int edges;
    bit leak;
    bit bad;
    logic [W:0] exp;
    exp = model(20'h18000);
    run_op(20'h18000, 1'b1, edges, leak);
    checks++;
    if (edges != W + 1 || leak) begin
      failures++;
      $display("FAIL hold_busy: edges=%0d leak=%b expected edges=%0d leak=0", edges, leak, W + 1);
    end
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      input_ready = 1'($urandom_range(0, 1));
      din = W'($urandom);
      @(posedge clk);
      @(negedge clk);
      if ({overflow, out} !== exp || state !== 2'b10) bad = 1'b1;
    end
    input_ready = 1'b0;
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL hold_done: out=%h ovf=%b state=%b expected out=%h ovf=%b state=10",
               out, overflow, state, exp[W-1:0], exp[W]);
    end
    take_result("hold");
  endtask

  task automatic test_async_reset();
    logic [W:0] got;
    int edges;
    bit leak;
    @(negedge clk);
    din = 20'h18000;
    input_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    input_ready = 1'b0;
    repeat (7) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (state !== 2'b00 || out !== '0 || done !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL busy_reset: state=%b out=%h done=%b ovf=%b expected all zero",
               state, out, done, overflow);
    end
    @(negedge clk);
    reset = 1'b1;
    check_op("after_busy_reset", 20'h10000, 1'b0, got);
    checks++;
    if (got !== {1'b0, 20'h10000}) begin
      failures++;
      $display("FAIL after_busy_reset_const: out=%h ovf=%b expected out=10000 ovf=0",
               got[W-1:0], got[W]);
    end
    run_op(20'hFFFFF, 1'b0, edges, leak);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (state !== 2'b00 || out !== '0 || done !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL done_reset: state=%b out=%h done=%b ovf=%b expected all zero",
               state, out, done, overflow);
    end
    @(negedge clk);
    reset = 1'b1;
    check_op("after_done_reset", 20'h000B6, 1'b0, got);
  endtask

  task automatic test_back_to_back();
    int edges;
    bit leak;
    logic [W-1:0] x2;
    logic [W:0] exp;
    x2 = W'($urandom_range(0, (1 << W) - 1));
    exp = model(x2);
    run_op(20'h20000, 1'b0, edges, leak);
    @(negedge clk);
    din = ~x2;
    input_ready = 1'b1;
    output_taken = 1'b1;
    @(posedge clk);
    @(negedge clk);
    output_taken = 1'b0;
    din = x2;
    checks++;
    if (state !== 2'b00 || out !== '0) begin
      failures++;
      $display("FAIL b2b_idle: state=%b out=%h expected state=00 out=0", state, out);
    end
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    input_ready = 1'b0;
    checks++;
    if (state !== 2'b01) begin
      failures++;
      $display("FAIL b2b_accept: state=%b expected 01", state);
    end
    while (!done && edges < 4 * W) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    checks++;
    if (edges != W + 1 || {overflow, out} !== exp) begin
      failures++;
      $display("FAIL b2b_result: in=%h edges=%0d out=%h ovf=%b expected edges=%0d out=%h ovf=%b",
               x2, edges, out, overflow, W + 1, exp[W-1:0], exp[W]);
    end
    take_result("b2b");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold_and_ignore();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/square.md
SQUARE -- requirements
Module: square

Interface
REQ-001 Parameter IL, default 4, integer bits of the unsigned fixed-point format.
REQ-002 Parameter FL, default 16, fraction bits of the unsigned fixed-point format; W = IL+FL.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in  input  W  unsigned QIL.FL operand x.
REQ-006 input_ready  input  1  operand valid; sampled only in IDLE.
REQ-007 output_taken  input  1  consumer acknowledge; sampled only in DONE.
REQ-008 out  output  W  unsigned QIL.FL result, rounded and saturated x*x.
REQ-009 state  output  2  FSM state: 00 IDLE, 01 BUSY, 10 DONE.
REQ-010 done  output  1  high exactly while state == DONE.
REQ-011 overflow  output  1  high in DONE when out was saturated.

Function
REQ-012 The FSM SHALL move IDLE->BUSY on input_ready=1 and latch in in that same edge.
REQ-013 The FSM SHALL stay in BUSY for exactly W cycles, then enter DONE.
REQ-014 BUSY SHALL form the 2W-bit product by shift-add, one multiplier bit per cycle, LSB first.
REQ-015 Latency from the accepting edge to done=1 SHALL be W+1 edges, i.e. 21 at default parameters.
REQ-016 The result SHALL be P>>FL plus P[FL-1] (round half up) for the full product P.
REQ-017 If the rounded value exceeds 2^W-1, out SHALL be all ones and overflow SHALL be 1; otherwise overflow SHALL be 0.
REQ-018 out and overflow SHALL be held constant throughout DONE.
REQ-019 DONE->IDLE SHALL occur on output_taken=1, clearing out, overflow and the working registers to 0 on that edge.
REQ-020 input_ready outside IDLE SHALL be ignored; no operand is queued.
REQ-021 output_taken outside DONE SHALL be ignored.
REQ-022 If input_ready and output_taken are both 1 in DONE, the block SHALL return to IDLE only; the next operand is accepted no earlier than the following edge.
REQ-023 State 11 SHALL transition to IDLE on the next edge, with out=0 and done=0.
REQ-024 out SHALL read 0 in IDLE and BUSY; intermediate sums SHALL never appear on out.

Reset
REQ-025 reset=0 SHALL immediately force state=IDLE, out=0, done=0, overflow=0, and clear the cycle counter and accumulator, independent of clk.
REQ-026 Reset asserted mid-BUSY or in DONE SHALL abandon the operation; after release the block SHALL accept a new operand with no residual state.
REQ-027 Reset release SHALL take effect from the first rising clk edge after deassertion.

Structure
REQ-028 The default IL/FL values and the 2-bit state encoding constants (IDLE/BUSY/DONE) SHALL live in a shared fixed-point package also used by the square-root unit.
REQ-029 The block SHALL be a single module with no sub-module; counter, accumulator, round and saturate logic are inline.
REQ-030 The cycle counter SHALL be sized ceil(log2(W+1)) bits and be derived from the parameters.

Verification
REQ-031 in=0x20000 (2.0) -> out=0x40000, overflow=0, done rises 21 edges after accept.
REQ-032 in=0x18000 (1.5) -> out=0x24000; in=0x000B5 -> out=0x00000; in=0x000B6 -> out=0x00001 (rounding boundary).
REQ-033 in=0x40000 (4.0) and in=0xFFFFF -> out=0xFFFFF, overflow=1.
REQ-034 Hold output_taken=0 for 10 cycles in DONE -> out is stable; pulsing input_ready during BUSY/DONE -> ignored; result unchanged.
REQ-035 Assert reset=0 at BUSY cycle 7 between edges -> state=00 and out=0 immediately; then in=0x10000 -> out=0x10000.
REQ-036 input_ready=1 and output_taken=1 together in DONE -> IDLE for one cycle, then accept in the next cycle.
